// File: rtl/div_hilo_unit.sv
// div_hilo_unit: multi-cycle restoring radix-2 divider that owns the HI/LO
// registers. It serves DIV/DIVU (LO=quotient, HI=remainder), MTHI/MTLO writes,
// and MFHI/MFLO reads through HiOut/LoOut.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start, Signed, A, B divide request and operands (sampled in IDLE only)
//   MoveHi, MoveLo      MTHI/MTLO strobes with MoveData (IDLE, Start=0 only)
//   Busy, Done          divide in progress / one-cycle completion pulse
//   DivByZero           set with Done when the divisor was zero
//   HiOut, LoOut        HI/LO register contents
module div_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MoveHi,
  input  logic             MoveLo,
  input  logic [WIDTH-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_op_q, zero_op_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes and signs (signs only matter in signed mode).
  logic               a_neg_c, b_neg_c;
  logic [WIDTH-1:0]   a_abs_c, b_abs_c;
  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  logic [WIDTH:0]     rem_shift_c, rem_sub_c;
  logic               rem_ge_c;

  always_comb begin
    a_neg_c     = Signed & A[WIDTH-1];
    b_neg_c     = Signed & B[WIDTH-1];
    a_abs_c     = a_neg_c ? WIDTH'(-A) : A;
    b_abs_c     = b_neg_c ? WIDTH'(-B) : B;
    rem_shift_c = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    rem_ge_c    = rem_shift_c >= {1'b0, dvsr_q};
    rem_sub_c   = rem_shift_c - {1'b0, dvsr_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_op_d  = zero_op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          cnt_d      = CNT_W'(WIDTH);
          rem_d      = '0;
          dvsr_d     = b_abs_c;
          neg_quot_d = a_neg_c ^ b_neg_c;
          neg_rem_d  = a_neg_c;
          if (B == '0) begin
            // Divide by zero skips the iterations; keep raw A for HI.
            zero_op_d = 1'b1;
            quot_d    = A;
            state_d   = FIX;
          end else begin
            zero_op_d = 1'b0;
            quot_d    = a_abs_c;
            state_d   = DIVIDE;
          end
        end else begin
          if (MoveHi) hi_d = MoveData;
          if (MoveLo) lo_d = MoveData;
        end
      end
      DIVIDE: begin
        rem_d  = rem_ge_c ? rem_sub_c : rem_shift_c;
        quot_d = {quot_q[WIDTH-2:0], rem_ge_c};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_op_q) begin
          hi_d  = quot_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = neg_quot_q ? WIDTH'(-quot_q) : quot_q;
          hi_d = neg_rem_q ? WIDTH'(-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_op_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_op_q  <= zero_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Testbench for div_hilo_unit: scoreboard of expected HI/LO/flag/latency
// pushed at Start and popped at Done, plus move and reset checks.
module tb_div_hilo_unit;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start, Signed, MoveHi, MoveLo;
  logic [W-1:0] A, B, MoveData;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  div_hilo_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Signed(Signed),
    .A(A), .B(B), .MoveHi(MoveHi), .MoveLo(MoveLo), .MoveData(MoveData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model using 64-bit arithmetic so the overflow case is exact.
  function automatic exp_t model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    if (b == '0) begin
      e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
    end else begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0]; e.hi = r[31:0]; e.dbz = 1'b0; e.lat = W + 1;
    end
    return e;
  endfunction

  // Launch one divide, track it to Done, compare against the scoreboard.
  task automatic run_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    exp_t e;
    int   n;
    bit   busy_ok, stable_ok;
    sb_q.push_back(model(sg, a, b));
    Signed = sg; A = a; B = b; Start = 1'b1;
    // Moves in the Start cycle must lose to Start.
    MoveHi = 1'b1; MoveLo = 1'b1; MoveData = 32'hFFFF0000;
    @(posedge Clk); #1;
    Start = 1'b0; MoveHi = 1'b0; MoveLo = 1'b0;
    A = ~a; B = $urandom; Signed = ~sg;
    check_eq("busy_at_start", 64'(Busy), 64'(1));
    check_eq("dbz_cleared", 64'(DivByZero), 64'(0));
    n = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    while (!Done && n < 100) begin
      if (!Busy) busy_ok = 1'b0;
      if (HiOut !== hi_m || LoOut !== lo_m) stable_ok = 1'b0;
      if (disturb && n == 5) begin
        Start = 1'b1; A = 32'h0000_0009; B = 32'h0000_0003;
        MoveLo = 1'b1; MoveHi = 1'b1; MoveData = 32'hBAD0BAD0;
      end else begin
        Start = 1'b0; MoveLo = 1'b0; MoveHi = 1'b0;
      end
      @(posedge Clk); #1;
      n++;
    end
    Start = 1'b0; MoveLo = 1'b0; MoveHi = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      check_eq("latency", 64'(n), 64'(e.lat));
      check_eq("hi", 64'(HiOut), 64'(e.hi));
      check_eq("lo", 64'(LoOut), 64'(e.lo));
      check_eq("dbz", 64'(DivByZero), 64'(e.dbz));
      check_eq("busy_at_done", 64'(Busy), 64'(0));
      check_eq("busy_window", 64'(busy_ok), 64'(1));
      check_eq("hilo_stable", 64'(stable_ok), 64'(1));
      hi_m = e.hi; lo_m = e.lo;
    end
    @(posedge Clk); #1;
    check_eq("done_pulse", 64'(Done), 64'(0));
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    MoveHi = 1'b0; MoveLo = 1'b0; MoveData = '0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_busy", 64'(Busy), 64'(0));
    check_eq("rst_done", 64'(Done), 64'(0));
    check_eq("rst_dbz", 64'(DivByZero), 64'(0));
    check_eq("rst_hi", 64'(HiOut), 64'(0));
    check_eq("rst_lo", 64'(LoOut), 64'(0));
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // MTHI alone, then MTHI+MTLO together.
    MoveHi = 1'b1; MoveData = 32'hDEADBEEF;
    @(posedge Clk); #1;
    MoveHi = 1'b0; hi_m = 32'hDEADBEEF;
    check_eq("mthi_hi", 64'(HiOut), 64'(hi_m));
    check_eq("mthi_lo", 64'(LoOut), 64'(lo_m));
    MoveHi = 1'b1; MoveLo = 1'b1; MoveData = 32'h0000_0055;
    @(posedge Clk); #1;
    MoveHi = 1'b0; MoveLo = 1'b0; hi_m = 32'h55; lo_m = 32'h55;
    check_eq("mtboth_hi", 64'(HiOut), 64'(hi_m));
    check_eq("mtboth_lo", 64'(LoOut), 64'(lo_m));

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
    run_div(1'b0, 32'h1234, 32'd0, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_div(1'b1, 32'h1234, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_div(1'(i % 2), $urandom, $urandom_range(1, 32'hFFFF) ^ (i > 2 ? 32'hFFFF0000 : 32'h0), 1'b0);
    end

    // Abort a divide with reset mid-flight.
    Signed = 1'b0; A = 32'd5000; B = 32'd9; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(Busy), 64'(0));
    check_eq("abort_hi", 64'(HiOut), 64'(0));
    check_eq("abort_lo", 64'(LoOut), 64'(0));
    hi_m = '0; lo_m = '0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    run_div(1'b0, 32'd1000, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
